// File: rtl/address_register_sequencer.sv
// address_register_sequencer
//   Multi-cycle controller for the PC/SP/AR address register file. Takes one
//   operation at a time over a valid/ready handshake, drives register select,
//   function select and output selects, and runs one memory request/ack per
//   memory operation. Memory address comes from the register file OutD; CALL
//   write data comes from OutC.
// Ports:
//   clock, reset_n          clock, synchronous active-low reset
//   op_valid/op_ready       operation handshake (ready only in IDLE)
//   op_code/op_operand      operation and its 16-bit operand (captured on accept)
//   mem_req/mem_we/mem_ack  memory handshake, mem_rdata read data
//   arf_regsel/arf_funsel   register enable (PC,SP,AR) and function select
//   arf_din                 register data input {16'b0, source}
//   arf_outc_sel/outd_sel   register file output selects
//   done/err                end-of-operation pulse, error pulse with done
module address_register_sequencer #(
  parameter logic [15:0] STACK_TOP = 16'hFFFE,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [15:0] op_operand,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  arf_regsel,
  output logic [1:0]  arf_funsel,
  output logic [31:0] arf_din,
  output logic [1:0]  arf_outc_sel,
  output logic [1:0]  arf_outd_sel,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_INIT_CLR, S_INIT_SP, S_IDLE, S_PRE, S_SEL, S_MEM,
    S_UPD, S_LDPC, S_LDAR, S_FIX, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP, OP_FETCH, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_LOAD_AR, OP_RSVD
  } op_e;

  localparam logic [1:0]  FS_DEC = 2'b00, FS_INC = 2'b01, FS_LOAD = 2'b10, FS_CLR = 2'b11;
  localparam logic [1:0]  SEL_PC = 2'b00, SEL_SP = 2'b01;
  localparam logic [2:0]  RS_PC = 3'b001, RS_SP = 3'b010, RS_AR = 3'b100;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] operand_q, operand_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        is_wr;
  logic [15:0] din16;

  assign is_wr = (op_q == OP_PUSH) || (op_q == OP_CALL);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_INIT_CLR;
      op_q      <= OP_NOP;
      operand_q <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // next state
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_INIT_CLR: state_d = S_INIT_SP;
      S_INIT_SP:  state_d = S_IDLE;
      S_IDLE: if (op_valid) begin
        op_d      = op_e'(op_code);
        operand_d = op_operand;
        err_d     = 1'b0;
        case (op_e'(op_code))
          OP_FETCH, OP_PUSH, OP_CALL: state_d = S_SEL;
          OP_POP, OP_RET:             state_d = S_PRE;
          OP_LOAD_AR:                 state_d = S_LDAR;
          OP_NOP:                     state_d = S_DONE;
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_PRE: state_d = S_SEL;
      S_SEL: begin
        cnt_d   = '0;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (mem_ack) begin
          cnt_d = '0;
          if (!is_wr) rdata_d = mem_rdata;
          if (op_q == OP_FETCH || is_wr) state_d = S_UPD;
          else if (op_q == OP_RET)       state_d = S_LDPC;
          else                           state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          // abandon: POP/RET already pre-incremented SP, so undo it
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = (op_q == OP_POP || op_q == OP_RET) ? S_FIX : S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_UPD:  state_d = (op_q == OP_CALL) ? S_LDPC : S_DONE;
      S_LDPC, S_LDAR, S_FIX: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_INIT_CLR;
    endcase
  end

  // Moore outputs. While reset_n is low every output is forced to its idle
  // value, so INIT_CLR only issues its clear once reset has been released.
  always_comb begin
    op_ready     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    arf_regsel   = 3'b000;
    arf_funsel   = FS_DEC;
    din16        = '0;
    arf_outc_sel = SEL_PC;
    arf_outd_sel = SEL_PC;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_INIT_CLR: begin arf_regsel = RS_PC | RS_AR; arf_funsel = FS_CLR; end
      S_INIT_SP:  begin arf_regsel = RS_SP; arf_funsel = FS_LOAD; din16 = STACK_TOP; end
      S_IDLE:     op_ready = 1'b1;
      S_PRE:      begin arf_regsel = RS_SP; arf_funsel = FS_INC; end
      S_SEL, S_MEM: begin
        // address select set in SEL and held through MEM
        arf_outd_sel = (op_q == OP_FETCH) ? SEL_PC : SEL_SP;
        if (state_q == S_MEM) begin
          mem_req = 1'b1;
          mem_we  = is_wr;
        end
      end
      S_UPD: begin
        arf_regsel = (op_q == OP_FETCH) ? RS_PC : RS_SP;
        arf_funsel = (op_q == OP_FETCH) ? FS_INC : FS_DEC;
      end
      S_LDPC: begin
        arf_regsel = RS_PC;
        arf_funsel = FS_LOAD;
        din16      = (op_q == OP_CALL) ? operand_q : rdata_q;
      end
      S_LDAR: begin arf_regsel = RS_AR; arf_funsel = FS_LOAD; din16 = operand_q; end
      S_FIX:  begin arf_regsel = RS_SP; arf_funsel = FS_DEC; end
      S_DONE: begin done = 1'b1; err = err_q; end
      default: ;
    endcase
    if (!reset_n) begin
      op_ready     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      arf_regsel   = 3'b000;
      arf_funsel   = FS_DEC;
      din16        = '0;
      arf_outc_sel = SEL_PC;
      arf_outd_sel = SEL_PC;
      done         = 1'b0;
      err          = 1'b0;
    end
  end

  assign arf_din = {16'b0, din16};

endmodule

// File: tb/tb_address_register_sequencer.sv
module tb_address_register_sequencer;
  logic        clock = 1'b0;
  logic        reset_n, op_valid, op_ready, mem_req, mem_we, mem_ack, done, err;
  logic [2:0]  op_code, arf_regsel;
  logic [15:0] op_operand, mem_rdata;
  logic [1:0]  arf_funsel, arf_outc_sel, arf_outd_sel;
  logic [31:0] arf_din;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  address_register_sequencer #(.STACK_TOP(16'hFFFE), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_operand(op_operand), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arf_regsel(arf_regsel),
    .arf_funsel(arf_funsel), .arf_din(arf_din), .arf_outc_sel(arf_outc_sel),
    .arf_outd_sel(arf_outd_sel), .done(done), .err(err));

  // inputs change and outputs are sampled on the falling edge
  task automatic accept(input logic [2:0] code, input logic [15:0] opnd);
    n_chk++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b want 1", op_ready); end
    op_valid = 1'b1; op_code = code; op_operand = opnd;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_operand = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clock);
    @(negedge clock);
    n_chk++;
    if ({op_ready, mem_req, mem_we, arf_regsel, arf_funsel, arf_outc_sel, arf_outd_sel, done, err} !== 14'b0 ||
        arf_din !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy%b req%b we%b rs%b fs%b din%h want all 0",
                         op_ready, mem_req, mem_we, arf_regsel, arf_funsel, arf_din);
    end
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (arf_regsel !== 3'b101 || arf_funsel !== 2'b11) begin
      n_fail++; $display("FAIL init_clr: got rs%b fs%b want 101 11", arf_regsel, arf_funsel); end
    @(negedge clock);
    n_chk++;
    if (arf_regsel !== 3'b010 || arf_funsel !== 2'b10 || arf_din !== 32'h0000FFFE || op_ready !== 1'b0) begin
      n_fail++; $display("FAIL init_sp: got rs%b fs%b din%h rdy%b want 010 10 0000fffe 0",
                         arf_regsel, arf_funsel, arf_din, op_ready); end
    @(negedge clock);
    n_chk++;
    if (op_ready !== 1'b1 || arf_regsel !== 3'b000) begin
      n_fail++; $display("FAIL init_idle: got rdy%b rs%b want 1 000", op_ready, arf_regsel); end
  endtask

  task automatic test_fetch;
    int nreq = 0;
    accept(3'd1, 16'h0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      op_valid = 1'b0;
      if (mem_req === 1'b1) nreq++;
      if (k >= 2 && k <= 4) begin
        n_chk++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || arf_outd_sel !== 2'b00) begin
          n_fail++; $display("FAIL fetch_mem k%0d: got req%b we%b od%b want 1 0 00", k, mem_req, mem_we, arf_outd_sel); end
      end
      mem_ack = (k == 4); mem_rdata = 16'hAAAA;
      case (k)
        1: begin n_chk++; if (arf_outd_sel !== 2'b00 || mem_req !== 1'b0 || op_ready !== 1'b0) begin
             n_fail++; $display("FAIL fetch_sel: got od%b req%b rdy%b want 00 0 0", arf_outd_sel, mem_req, op_ready); end end
        5: begin n_chk++; if (arf_regsel !== 3'b001 || arf_funsel !== 2'b01 || mem_req !== 1'b0) begin
             n_fail++; $display("FAIL fetch_upd: got rs%b fs%b req%b want 001 01 0", arf_regsel, arf_funsel, mem_req); end end
        6: begin n_chk++; if (done !== 1'b1 || err !== 1'b0 || arf_regsel !== 3'b000) begin
             n_fail++; $display("FAIL fetch_done: got done%b err%b rs%b want 1 0 000", done, err, arf_regsel); end end
        7: begin n_chk++; if (done !== 1'b0 || op_ready !== 1'b1) begin
             n_fail++; $display("FAIL fetch_idle: got done%b rdy%b want 0 1", done, op_ready); end end
        default: ;
      endcase
    end
    n_chk++;
    if (nreq != 3) begin n_fail++; $display("FAIL fetch_req_len: got %0d want 3", nreq); end
  endtask

  task automatic test_call_ret;
    accept(3'd4, 16'h1234);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      op_valid = 1'b0;
      mem_ack = (k == 2);
      case (k)
        1: begin n_chk++; if (arf_outd_sel !== 2'b01 || arf_outc_sel !== 2'b00 || mem_req !== 1'b0) begin
             n_fail++; $display("FAIL call_sel: got od%b oc%b req%b want 01 00 0", arf_outd_sel, arf_outc_sel, mem_req); end end
        2: begin n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || arf_outd_sel !== 2'b01 || arf_outc_sel !== 2'b00) begin
             n_fail++; $display("FAIL call_mem: got req%b we%b od%b oc%b want 1 1 01 00", mem_req, mem_we, arf_outd_sel, arf_outc_sel); end end
        3: begin n_chk++; if (arf_regsel !== 3'b010 || arf_funsel !== 2'b00 || mem_req !== 1'b0) begin
             n_fail++; $display("FAIL call_spdec: got rs%b fs%b req%b want 010 00 0", arf_regsel, arf_funsel, mem_req); end end
        4: begin n_chk++; if (arf_regsel !== 3'b001 || arf_funsel !== 2'b10 || arf_din !== 32'h00001234) begin
             n_fail++; $display("FAIL call_ldpc: got rs%b fs%b din%h want 001 10 00001234", arf_regsel, arf_funsel, arf_din); end end
        5: begin n_chk++; if (done !== 1'b1 || err !== 1'b0) begin
             n_fail++; $display("FAIL call_done: got done%b err%b want 1 0", done, err); end end
        default: ;
      endcase
    end
    accept(3'd5, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      op_valid = 1'b0;
      mem_ack = (k == 3); mem_rdata = (k == 3) ? 16'h0042 : 16'hDEAD;
      case (k)
        1: begin n_chk++; if (arf_regsel !== 3'b010 || arf_funsel !== 2'b01 || mem_req !== 1'b0) begin
             n_fail++; $display("FAIL ret_spinc: got rs%b fs%b req%b want 010 01 0", arf_regsel, arf_funsel, mem_req); end end
        2: begin n_chk++; if (arf_outd_sel !== 2'b01 || arf_regsel !== 3'b000 || mem_req !== 1'b0) begin
             n_fail++; $display("FAIL ret_sel: got od%b rs%b req%b want 01 000 0", arf_outd_sel, arf_regsel, mem_req); end end
        3: begin n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
             n_fail++; $display("FAIL ret_mem: got req%b we%b want 1 0", mem_req, mem_we); end end
        4: begin n_chk++; if (arf_regsel !== 3'b001 || arf_funsel !== 2'b10 || arf_din !== 32'h00000042) begin
             n_fail++; $display("FAIL ret_ldpc: got rs%b fs%b din%h want 001 10 00000042", arf_regsel, arf_funsel, arf_din); end end
        5: begin n_chk++; if (done !== 1'b1 || err !== 1'b0) begin
             n_fail++; $display("FAIL ret_done: got done%b err%b want 1 0", done, err); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_pop_timeout;
    int nreq = 0;
    int bad_wr = 0;
    accept(3'd3, 16'h0);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clock);
      op_valid = 1'b0;
      if (mem_req === 1'b1) nreq++;
      if (arf_regsel[0] === 1'b1 || arf_regsel[2] === 1'b1) bad_wr++;
      mem_ack = (k == 1 || k == 2);  // acks outside MEM must be ignored
      case (k)
        1:  begin n_chk++; if (arf_regsel !== 3'b010 || arf_funsel !== 2'b01) begin
              n_fail++; $display("FAIL pop_spinc: got rs%b fs%b want 010 01", arf_regsel, arf_funsel); end end
        18: begin n_chk++; if (mem_req !== 1'b1) begin
              n_fail++; $display("FAIL pop_last_req: got %b want 1", mem_req); end end
        19: begin n_chk++; if (arf_regsel !== 3'b010 || arf_funsel !== 2'b00 || mem_req !== 1'b0 || done !== 1'b0) begin
              n_fail++; $display("FAIL pop_fix: got rs%b fs%b req%b done%b want 010 00 0 0", arf_regsel, arf_funsel, mem_req, done); end end
        20: begin n_chk++; if (done !== 1'b1 || err !== 1'b1) begin
              n_fail++; $display("FAIL pop_done_err: got done%b err%b want 1 1", done, err); end end
        21: begin n_chk++; if (op_ready !== 1'b1 || err !== 1'b0) begin
              n_fail++; $display("FAIL pop_idle: got rdy%b err%b want 1 0", op_ready, err); end end
        default: ;
      endcase
    end
    n_chk++;
    if (nreq != 16) begin n_fail++; $display("FAIL pop_req_len: got %0d want 16", nreq); end
    n_chk++;
    if (bad_wr != 0) begin n_fail++; $display("FAIL pop_pc_ar_write: got %0d want 0", bad_wr); end
  endtask

  task automatic test_short_ops;
    logic [2:0] codes [3];
    codes[0] = 3'd0; codes[1] = 3'd7; codes[2] = 3'd6;
    for (int i = 0; i < 3; i++) begin
      accept(codes[i], 16'hBEEF);
      @(negedge clock);
      op_valid = 1'b0;
      if (codes[i] == 3'd6) begin
        n_chk++;
        if (arf_regsel !== 3'b100 || arf_funsel !== 2'b10 || arf_din !== 32'h0000BEEF || done !== 1'b0) begin
          n_fail++; $display("FAIL ldar: got rs%b fs%b din%h done%b want 100 10 0000beef 0", arf_regsel, arf_funsel, arf_din, done); end
        @(negedge clock);
      end
      n_chk++;
      if (done !== 1'b1 || err !== (codes[i] == 3'd7) || arf_regsel !== 3'b000) begin
        n_fail++; $display("FAIL short_done op%0d: got done%b err%b rs%b want 1 %b 000", codes[i], done, err, arf_regsel, codes[i] == 3'd7); end
      @(negedge clock);
      n_chk++;
      if (op_ready !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL short_idle op%0d: got rdy%b done%b want 1 0", codes[i], op_ready, done); end
    end
  endtask

  task automatic test_reset_mid_push;
    accept(3'd2, 16'h0);
    @(negedge clock);  // SEL
    op_valid = 1'b0;
    @(negedge clock);  // MEM
    n_chk++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL push_mem: got req%b we%b want 1 1", mem_req, mem_we); end
    reset_n = 1'b0;
    @(negedge clock);
    n_chk++;
    if (mem_req !== 1'b0 || arf_regsel !== 3'b000 || done !== 1'b0) begin
      n_fail++; $display("FAIL push_abort: got req%b rs%b done%b want 0 000 0", mem_req, arf_regsel, done); end
    reset_n = 1'b1; mem_ack = 1'b1;
    #1;
    n_chk++;
    if (arf_regsel !== 3'b101 || arf_funsel !== 2'b11 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL push_reinit_clr: got rs%b fs%b req%b want 101 11 0", arf_regsel, arf_funsel, mem_req); end
    @(negedge clock);
    n_chk++;
    if (arf_regsel !== 3'b010 || arf_funsel !== 2'b10 || arf_din !== 32'h0000FFFE || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL push_reinit_sp: got rs%b fs%b din%h req%b want 010 10 0000fffe 0", arf_regsel, arf_funsel, arf_din, mem_req); end
    @(negedge clock);
    mem_ack = 1'b0;
    n_chk++;
    if (op_ready !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0 || arf_regsel !== 3'b000) begin
      n_fail++; $display("FAIL push_reinit_idle: got rdy%b req%b done%b rs%b want 1 0 0 000", op_ready, mem_req, done, arf_regsel); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_call_ret();
    test_pop_timeout();
    test_short_ops();
    test_reset_mid_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/address_register_sequencer.md
Name: address_register_sequencer

Overview:
Multi-cycle controller that drives the control inputs of the PC/SP/AR address register file. It accepts one address operation at a time over a valid/ready handshake: FETCH, PUSH, POP, CALL, RET or LOAD_AR. It sequences register selection, function select and output selects, and runs a single memory request/acknowledge transaction per operation. The address register file drives the memory address from OutD; CALL write data comes from OutC.

Parameters:
STACK_TOP, 16'hFFFE, value loaded into SP during post-reset init
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack (must be ≥2)

Ports:
clock  in  1  single clock; all state changes on posedge
reset_n  in  1  synchronous, active-low reset
op_valid  in  1  operation request
op_ready  out  1  high only in IDLE; accept = op_valid & op_ready at posedge
op_code  in  3  000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110 LOAD_AR, 111 reserved
op_operand  in  16  CALL target / LOAD_AR value; captured on accept
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  1 = write; valid while mem_req
mem_ack  in  1  completes request in the cycle it is sampled high with mem_req
mem_rdata  in  16  read data; captured when mem_ack sampled on a read
arf_regsel  out  3  one-hot enable: bit0 PC, bit1 SP, bit2 AR
arf_funsel  out  2  00 decrement, 01 increment, 10 load, 11 clear
arf_din  out  32  register file data input: {16'b0, selected 16-bit source}
arf_outc_sel  out  2  00 PC, 01 SP, 10 AR
arf_outd_sel  out  2  00 PC, 01 SP, 10 AR
done  out  1  one-cycle pulse at end of every accepted operation
err  out  1  one-cycle pulse with done on timeout or reserved opcode

Behaviour:
- Reset (reset_n low at posedge): state INIT_CLR, timeout counter 0, captured operand/rdata 0.
- Reset output values: mem_req 0, mem_we 0, arf_regsel 000, arf_funsel 00, selects 00, arf_din 0, op_ready 0, done 0, err 0.
- Reset mid-operation aborts immediately: mem_req low from the reset edge; no register-file fix-up.
- Post-reset init:
  - INIT_CLR (1 cycle): regsel 101, funsel 11.
  - INIT_SP (1 cycle): regsel 010, funsel 10, arf_din = STACK_TOP.
  - Then IDLE.
- Outputs are decoded from state only (Moore). arf_regsel is 000 in every state not listed below as writing a register.
- The register file outputs are registered, so every memory access has one SEL cycle before MEM. In SEL, outd_sel is set and then held through MEM.
- Per-op state sequences (each state is 1 cycle except MEM):
  - FETCH: SEL(outd=PC) -> MEM(rd) -> UPD(PC inc) -> DONE
  - PUSH: SEL(outd=SP) -> MEM(wr) -> UPD(SP dec) -> DONE
  - POP: PRE(SP inc) -> SEL(outd=SP) -> MEM(rd) -> DONE
  - CALL: SEL(outd=SP, outc=PC) -> MEM(wr) -> UPD(SP dec) -> LDPC(PC load, arf_din = operand) -> DONE
  - RET: PRE(SP inc) -> SEL(outd=SP) -> MEM(rd) -> LDPC(PC load, arf_din = captured rdata) -> DONE
  - LOAD_AR: LDAR(AR load, arf_din = operand) -> DONE
  - NOP: DONE
  - reserved: DONE with err=1
- MEM state:
  - mem_req=1; mem_we=1 for PUSH/CALL, 0 otherwise.
  - An ack in the first MEM cycle is legal (one MEM cycle).
  - mem_ack outside MEM is ignored.
- Timeout:
  - The counter increments each MEM cycle without ack.
  - When the counter reaches TIMEOUT-1 without ack, mem_req drops next cycle. No UPD/LDPC is performed.
  - POP/RET timeout: go to FIX (SP dec, 1 cycle) so SP is restored, then DONE.
  - DONE pulses done=1 and err=1.
- DONE: done=1 for one cycle, then IDLE; op_ready=1 from the following cycle. Back-to-back ops therefore have one idle cycle minimum.
- Latency from accept edge to done (ack at first MEM cycle): FETCH/PUSH 4 cycles, POP 4, CALL 5, RET 5, LOAD_AR 2, NOP 1.
- Register widths: 16-bit ops; arf_din upper 16 bits always 0. Wrap-around of PC/SP is the register file's job; no checks here.

Test Plan:
- Reset release: reset_n 0 for 2 clocks, then 1 -> regsel 101/funsel 11, then regsel 010/funsel 10/arf_din 0x0000FFFE, then op_ready=1; all other outputs at reset values before release.
- FETCH, ack delayed 2 cycles -> outd_sel 00 from SEL; mem_req high 3 cycles with mem_we 0; then one cycle regsel 001/funsel 01; done at accept+6, err 0.
- CALL operand 0x1234 then RET returning mem_rdata 0x0042 -> CALL: mem_we 1, outc_sel 00, SP dec, PC load with arf_din 0x00001234. RET: SP inc before SEL, PC load with arf_din 0x00000042.
- POP with no ack (TIMEOUT=16) -> mem_req high exactly 16 cycles; SP inc then FIX SP dec; done and err pulse together; no PC/AR write.
- Reserved opcode 111 and NOP -> done one cycle after accept; err 1 only for 111; regsel stays 000.
- reset_n low during PUSH MEM -> mem_req 0 from that edge, no SP dec, init sequence restarts; mem_ack arriving later is ignored.
